// File: rtl/pwm_multichannel.sv
// rtl/pwm_multichannel.sv - multi-channel PWM with shared period counter and shadowed duty/period
module pwm_multichannel #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                center,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] polarity,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_end
);

    localparam logic [CW:0] CH_LIMIT = (CW+1)'(CHANNELS);

    logic [WIDTH-1:0]    duty_sh  [CHANNELS];
    logic [WIDTH-1:0]    duty_act [CHANNELS];
    logic [WIDTH-1:0]    period_act;
    logic                mode_act;
    logic [WIDTH-1:0]    cnt;
    logic                dir_down;

    logic [WIDTH-1:0]    cnt_nxt;
    logic                dir_down_nxt;
    logic                reload;
    logic [CHANNELS-1:0] pwm_run;
    logic                wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

    // Center mode with P=0 collapses to edge behaviour; P=1 in center mode
    // reaches the 1->0 reload directly from the top of the count.
    always_comb begin
        reload       = 1'b0;
        cnt_nxt      = cnt + WIDTH'(1);
        dir_down_nxt = dir_down;
        if (!mode_act || period_act == '0) begin
            if (cnt >= period_act) begin
                reload  = 1'b1;
                cnt_nxt = '0;
            end
        end else if (!dir_down) begin
            if (cnt >= period_act) begin
                if (period_act == WIDTH'(1)) begin
                    reload  = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    dir_down_nxt = 1'b1;
                    cnt_nxt      = cnt - WIDTH'(1);
                end
            end
        end else begin
            cnt_nxt = cnt - WIDTH'(1);
            if (cnt <= WIDTH'(1)) begin
                reload  = 1'b1;
                cnt_nxt = '0;
            end
        end
        if (reload) begin
            dir_down_nxt = 1'b0;
        end
    end

    always_comb begin
        pwm_run = polarity;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_en[i]) begin
                pwm_run[i] = (cnt < duty_act[i]) ^ polarity[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
            period_act <= '0;
            mode_act   <= 1'b0;
            cnt        <= '0;
            dir_down   <= 1'b0;
            pwm        <= '0;
            period_end <= 1'b0;
        end else begin
            if (wr_ok) begin
                duty_sh[wr_ch] <= wr_duty;
            end
            if (!start) begin
                cnt        <= '0;
                dir_down   <= 1'b0;
                pwm        <= polarity;
                period_end <= 1'b0;
                duty_act   <= duty_sh;
                period_act <= period;
                mode_act   <= center;
            end else begin
                cnt        <= cnt_nxt;
                dir_down   <= dir_down_nxt;
                pwm        <= pwm_run;
                period_end <= reload;
                // Active set is taken from the pre-write shadow on the reload edge.
                if (reload) begin
                    duty_act   <= duty_sh;
                    period_act <= period;
                    mode_act   <= center;
                end
            end
        end
    end

endmodule
